// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI4 burst initiator with a user command / beat-stream front end.
// Optional bus watchdog is compiled in when AXI_MASTER_TIMEOUT_EN is defined.
module axi_burst_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  timeout,
    output logic [ID_WIDTH-1:0]   awid,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_WIDTH-1:0]   bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ID_WIDTH-1:0]   arid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [8:0]            cnt_q, cnt_d;
    logic [1:0]            resp_q, resp_d;
    logic                  err_q, err_d;
    logic                  to_q, to_d;
    logic                  last_beat;
    logic                  hs;

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    // 9-bit count so len=255 (256 beats) compares without wrapping
    assign last_beat = (cnt_q == {1'b0, len_q});

    always_comb begin
        hs = 1'b0;
        unique case (state_q)
            S_AW:    hs = awready;
            S_W:     hs = wr_valid && wready;
            S_B:     hs = bvalid;
            S_AR:    hs = arready;
            S_R:     hs = rvalid && rd_ready;
            default: hs = 1'b0;
        endcase
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wdog_q, wdog_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            to_q    <= to_d;
`ifdef AXI_MASTER_TIMEOUT_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        err_d   = err_q;
        to_d    = to_q;
        unique case (state_q)
            S_IDLE: if (cmd_valid) begin
                addr_d  = cmd_addr;
                len_d   = cmd_len;
                size_d  = cmd_size;
                burst_d = cmd_burst;
                id_d    = cmd_id;
                cnt_d   = '0;
                resp_d  = 2'b00;
                err_d   = 1'b0;
                to_d    = 1'b0;
                state_d = cmd_write ? S_AW : S_AR;
            end
            S_AW: if (hs) state_d = S_W;
            S_AR: if (hs) state_d = S_R;
            S_W: if (hs) begin
                cnt_d = cnt_q + 9'd1;
                if (last_beat) state_d = S_B;
            end
            S_B: if (hs) begin
                resp_d = bresp;
                if (bid != id_q) err_d = 1'b1;
                state_d = S_DONE;
            end
            S_R: if (hs) begin
                cnt_d = cnt_q + 9'd1;
                if (rresp > resp_q) resp_d = rresp;
                // rlast must coincide exactly with beat len
                if (rid != id_q || rlast != last_beat) err_d = 1'b1;
                if (rlast || last_beat) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef AXI_MASTER_TIMEOUT_EN
        wdog_d = wdog_q;
        if (state_q == S_IDLE || state_q == S_DONE || hs) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_d == WDW'(TIMEOUT_CYCLES)) begin
                state_d = S_DONE;
                to_d    = 1'b1;
                err_d   = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE) && !rst;
        awid      = id_q;
        awaddr    = addr_q;
        awlen     = len_q;
        awsize    = size_q;
        awburst   = burst_q;
        awvalid   = (state_q == S_AW);
        arid      = id_q;
        araddr    = addr_q;
        arlen     = len_q;
        arsize    = size_q;
        arburst   = burst_q;
        arvalid   = (state_q == S_AR);
        wdata     = wr_data;
        wstrb     = 4'hF;
        wvalid    = (state_q == S_W) && wr_valid;
        wlast     = (state_q == S_W) && last_beat;
        wr_ready  = (state_q == S_W) && wready;
        bready    = (state_q == S_B);
        rd_data   = rdata;
        rd_valid  = (state_q == S_R) && rvalid;
        rd_last   = (state_q == S_R) && rlast;
        rready    = (state_q == S_R) && rd_ready;
        done      = (state_q == S_DONE);
        done_resp = (state_q == S_DONE) ? (err_q ? 2'b10 : resp_q) : 2'b00;
        timeout   = (state_q == S_DONE) && to_q;
    end

endmodule
